count_cmd_gen: RTL and testbench

Input-conditioning stage that sits directly upstream of the synchronous 0..20 up/down counter. It turns two raw push-buttons into a debounced command stream and drives the counter's `cn` (count enable, one-cycle pulse) and `ct` (direction: 0 = up, 1 = down) inputs. Holding a button produces auto-repeat pulses after a hold delay. Pressing both buttons at once is rejected.

---
 rtl/count_cmd_pkg.sv | 14 +
 rtl/btn_debounce.sv | 39 +++
 rtl/count_cmd_gen.sv | 96 +++++++++
 tb/tb_count_cmd_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/count_cmd_pkg.sv
// Shared types for the push-button command generator: FSM states and counter direction codes.
package count_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    localparam logic CT_UP = 1'b0;
    localparam logic CT_DN = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one raw push-button.
module btn_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            // Any sample matching the accepted level restarts the qualification window.
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign db = r_db;

endmodule

// File: rtl/count_cmd_gen.sv
// Debounced up/down push-button front end that emits single-cycle count pulses with hold-to-repeat.
module count_cmd_gen
    import count_cmd_pkg::*;
#(
    parameter int DB_CYCLES   = 50000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int RPT_CYCLES  = 5000000,
    parameter int CNT_W       = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    output logic cn,
    output logic ct,
    output logic held
);

    localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RPT_T  = CNT_W'(RPT_CYCLES);

    logic w_u, w_d, w_u_rise, w_d_rise, w_act;
    logic [CNT_W-1:0] w_tgt;

    state_t           r_state;
    logic             r_u_q, r_d_q;
    logic [CNT_W-1:0] r_tmr;
    logic             r_cn, r_ct;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_up (
        .clk (clk), .rst (rst), .raw (btn_up), .db (w_u)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_dn (
        .clk (clk), .rst (rst), .raw (btn_dn), .db (w_d)
    );

    assign w_u_rise = w_u & ~r_u_q;
    assign w_d_rise = w_d & ~r_d_q;
    assign w_act    = (r_ct == CT_DN) ? w_d : w_u;
    assign w_tgt    = (r_state == HOLD) ? HOLD_T : RPT_T;

    // Timer is loaded with 1 on each pulse so that reaching w_tgt lands exactly w_tgt cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_u_q   <= 1'b0;
            r_d_q   <= 1'b0;
            r_tmr   <= '0;
            r_cn    <= 1'b0;
            r_ct    <= CT_UP;
        end else begin
            r_u_q <= w_u;
            r_d_q <= w_d;
            r_cn  <= 1'b0;
            if (r_tmr != '1) r_tmr <= r_tmr + 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_u && w_d) begin
                        r_state <= LOCK;
                    end else if (w_u_rise) begin
                        r_cn    <= 1'b1;
                        r_ct    <= CT_UP;
                        r_state <= HOLD;
                        r_tmr   <= CNT_W'(1);
                    end else if (w_d_rise) begin
                        r_cn    <= 1'b1;
                        r_ct    <= CT_DN;
                        r_state <= HOLD;
                        r_tmr   <= CNT_W'(1);
                    end
                end
                HOLD, REPEAT: begin
                    if (w_u && w_d) begin
                        r_state <= LOCK;
                    end else if (!w_act) begin
                        r_state <= IDLE;
                    end else if (r_tmr == w_tgt) begin
                        r_cn    <= 1'b1;
                        r_state <= REPEAT;
                        r_tmr   <= CNT_W'(1);
                    end
                end
                LOCK: begin
                    if (!w_u && !w_d) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cn   = r_cn;
    assign ct   = r_ct;
    assign held = (r_state == HOLD) || (r_state == REPEAT);

endmodule

// File: tb/tb_count_cmd_gen.sv
// Directed bench for count_cmd_gen: press timing, bounce, auto-repeat, lockout, reset and a counter chain.
module tb_count_cmd_gen;
    import count_cmd_pkg::*;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;
    logic cn, ct, held;

    typedef struct {
        int e;
        int ct;
    } pulse_t;

    pulse_t pq[$];
    int     ecnt = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    int     n_consec = 0;
    logic   prev_cn = 1'b0;
    logic   cnt_clr = 1'b0;
    int     cval = 0;
    int     base;

    count_cmd_gen #(
        .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
        .cn(cn), .ct(ct), .held(held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        if (cn) pq.push_back('{ecnt, int'(ct)});
        if (cn && prev_cn) n_consec <= n_consec + 1;
        prev_cn <= cn;
    end

    // Reference 0..20 up/down counter fed by the block under test.
    always @(posedge clk) begin
        if (cnt_clr)
            cval <= 0;
        else if (cn)
            cval <= (ct == CT_UP) ? ((cval == 20) ? 0 : cval + 1) : ((cval == 0) ? 20 : cval - 1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d exp %0d", tag, got, exp);
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_pulse(input string tag, input int idx, input int e_exp, input int ct_exp);
        if (idx < pq.size()) begin
            chk({tag, "_edge"}, pq[idx].e, e_exp);
            chk({tag, "_ct"}, pq[idx].ct, ct_exp);
        end else begin
            chk({tag, "_missing"}, pq.size(), idx + 1);
        end
    endtask

    task automatic press(input logic dn);
        if (dn) btn_dn = 1'b1; else btn_up = 1'b1;
        wt(8);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        wt(16);
    endtask

    initial begin
        #2;
        chk("rst_cn", int'(cn), 0);
        chk("rst_ct", int'(ct), 0);
        chk("rst_held", int'(held), 0);
        chk("rst_state", int'(dut.r_state), int'(IDLE));
        wt(1);
        rst = 1'b1;
        wt(3);

        // Clean press: pulse after edge 6, released before hold expires
        pq.delete();
        base = ecnt + 1;
        btn_up = 1'b1;
        wt(8);
        chk("clean_held", int'(held), 1);
        btn_up = 1'b0;
        wt(20);
        chk("clean_npulse", pq.size(), 1);
        chk_pulse("clean", 0, base + 6, 0);
        chk("clean_held_off", int'(held), 0);

        // Bounce 1,0,1,0,1 then steady
        pq.delete();
        base = ecnt + 1;
        btn_dn = 1'b1; wt(1);
        btn_dn = 1'b0; wt(1);
        btn_dn = 1'b1; wt(1);
        btn_dn = 1'b0; wt(1);
        btn_dn = 1'b1; wt(8);
        btn_dn = 1'b0;
        wt(20);
        chk("bounce_npulse", pq.size(), 1);
        chk_pulse("bounce", 0, base + 10, 1);

        // Auto-repeat with 30-cycle hold
        pq.delete();
        base = ecnt + 1;
        btn_up = 1'b1;
        wt(30);
        btn_up = 1'b0;
        wt(20);
        chk("rpt_npulse", pq.size(), 8);
        chk_pulse("rpt0", 0, base + 6, 0);
        chk_pulse("rpt1", 1, base + 16, 0);
        chk_pulse("rpt2", 2, base + 19, 0);
        chk_pulse("rpt3", 3, base + 22, 0);
        chk_pulse("rpt7", 7, base + 34, 0);
        chk("rpt_idle", int'(dut.r_state), int'(IDLE));

        // Both pressed: lockout until both released
        pq.delete();
        base = ecnt + 1;
        btn_up = 1'b1;
        wt(8);
        btn_dn = 1'b1;
        wt(18);
        chk("both_state", int'(dut.r_state), int'(LOCK));
        chk("both_held", int'(held), 0);
        chk("both_npulse", pq.size(), 1);
        chk_pulse("both0", 0, base + 6, 0);
        btn_dn = 1'b0;
        wt(15);
        chk("dnrel_npulse", pq.size(), 1);
        chk("dnrel_state", int'(dut.r_state), int'(LOCK));
        btn_up = 1'b0;
        wt(15);
        chk("allrel_state", int'(dut.r_state), int'(IDLE));
        pq.delete();
        base = ecnt + 1;
        btn_dn = 1'b1;
        wt(8);
        btn_dn = 1'b0;
        wt(15);
        chk("after_lock_npulse", pq.size(), 1);
        chk_pulse("after_lock", 0, base + 6, 1);

        // Reset in the middle of a repeat pulse
        pq.delete();
        base = ecnt + 1;
        btn_up = 1'b1;
        wt(23);
        chk("pre_rst_cn", int'(cn), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cn", int'(cn), 0);
        chk("mid_rst_ct", int'(ct), 0);
        chk("mid_rst_held", int'(held), 0);
        wt(3);
        rst = 1'b1;
        pq.delete();
        base = ecnt + 1;
        wt(9);
        btn_up = 1'b0;
        wt(15);
        chk("post_rst_npulse", pq.size(), 1);
        chk_pulse("post_rst", 0, base + 6, 0);

        // Chain into the 0..20 counter
        cnt_clr = 1'b1;
        wt(1);
        cnt_clr = 1'b0;
        chk("chain_start", cval, 0);
        press(1'b0);
        chk("chain_up1", cval, 1);
        press(1'b0);
        chk("chain_up2", cval, 2);
        press(1'b0);
        chk("chain_up3", cval, 3);
        press(1'b1);
        chk("chain_dn", cval, 2);

        chk("cn_consec", n_consec, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
